stereo_delay_line_controller: RTL and testbench
===============================================

STEREO_DELAY_LINE_CONTROLLER -- requirements
Module: stereo_delay_line_controller

Interface
REQ-001 SHALL have parameter audio_width, default 32, sample width in bits.
REQ-002 SHALL have parameter addr_width, default 10, external RAM address width in words.
REQ-003 SHALL have parameter delay_samples, default 512, per-channel delay in stereo frames; legal range 2..2^(addr_width-1).
REQ-004 SHALL provide ports, one clock, reset asynchronous active-low:
- clk  in  1  sole clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  input sample valid
- i_ready  out  1  controller can accept a sample
- i_is_left  in  1  input sample is left channel
- i_audio  in  audio_width  input sample
- i_enable  in  1  1 = output delayed sample; 0 = output current sample (bypass)
- o_valid  out  1  output sample valid
- o_ready  in  1  downstream accepts output
- o_is_left  out  1  output sample channel
- o_audio  out  audio_width  output sample
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable (qualified by mem_en)
- mem_addr  out  addr_width  RAM word address
- mem_wdata  out  audio_width  RAM write data
- mem_rdata  in  audio_width  RAM read data, valid exactly 1 cycle after a read strobe
- o_sync_error  out  1  sticky channel-order error flag

Function
REQ-005 SHALL implement a 4-state FSM: IDLE, RD, WR, OUT; transitions IDLE->RD on i_valid, RD->WR unconditionally, WR->OUT unconditionally, OUT->IDLE when o_ready is high.
REQ-006 i_ready SHALL be 1 only in IDLE; a sample is accepted on the edge where i_valid && i_ready, which latches i_audio, i_is_left and i_enable.
REQ-007 RAM address SHALL be {ptr, ~is_left}: left at even words, right at odd words; ptr ranges 0..delay_samples-1.
REQ-008 In RD: mem_en=1, mem_we=0, mem_addr = address of latched sample.
REQ-009 In WR: register mem_rdata as the delayed sample; drive mem_en=1, mem_we=1, same mem_addr, mem_wdata = latched sample (read-before-write at the same location).
REQ-010 mem_en SHALL be 0 in IDLE and OUT; mem_we SHALL be 0 whenever mem_en is 0.
REQ-011 In OUT: o_valid=1, o_is_left = latched channel; o_audio = latched sample if latched i_enable=0, else delayed sample if the filled flag is set, else 0.
REQ-012 o_valid and o_audio SHALL hold stable while o_ready is low (backpressure); the FSM stays in OUT.
REQ-013 Latency: o_valid SHALL rise 3 cycles after the accept edge; minimum sample period 4 cycles.
REQ-014 ptr SHALL advance on OUT->IDLE only when the latched channel is right; it wraps from delay_samples-1 to 0.
REQ-015 The filled flag SHALL set on the first ptr wrap and stay set until reset; before that, delayed outputs are 0 (RAM content is uninitialized).
REQ-016 Expected channel SHALL start as left and toggle on each accepted sample. A sample whose i_is_left differs from the expected channel SHALL set o_sync_error, be processed normally, and resynchronize the expected channel to the opposite of the received channel.
REQ-017 Changes to i_enable while a sample is in flight SHALL NOT affect that sample.

Reset
REQ-018 While reset_n=0: state=IDLE, ptr=0, filled=0, expected=left, o_sync_error=0, o_valid=0, o_is_left=0, o_audio=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; i_ready=1 after reset_n deasserts.
REQ-019 Reset asserted mid-operation SHALL abort any in-flight sample immediately; no RAM write is issued for it after reset.

Verification (delay_samples=4, audio_width=32, single-cycle RAM model)
REQ-020 Basic: enable=1, frames L=n, R=0x100+n for n=1..8 with o_ready=1 -> first 4 frames output 0; frame 5 outputs L=1, R=0x101; frame 8 outputs L=4, R=0x104.
REQ-021 Timing: accept at edge T -> mem read strobe in cycle T+1, write strobe with mem_addr=0 (left)/1 (right) in cycle T+2, o_valid at T+3; i_ready low for T+1..T+3.
REQ-022 Bypass: enable=0, send L=0xABCD, R=0x0123 -> outputs 0xABCD then 0x0123 with matching o_is_left; RAM still written.
REQ-023 Backpressure: hold o_ready=0 for 10 cycles in OUT -> o_valid and o_audio stable, i_ready=0, no mem_en; output completes on the first o_ready=1 cycle.
REQ-024 Sync: send L, L, R -> o_sync_error=1 after the second sample and stays 1; the third sample (R) raises no new error; mem_addr follows each sample's own i_is_left.
REQ-025 Reset: assert reset_n=0 in WR state -> mem_en falls at once, o_valid=0; after release the first 4 frames output 0 again.

Source files
------------

// File: rtl/stereo_delay_line_controller_if.sv
// stereo_delay_line_controller_if: sample stream, bypass control and external RAM port of the stereo delay line
interface stereo_delay_line_controller_if #(
  parameter int audio_width = 32,
  parameter int addr_width = 10
);
  logic i_valid, i_ready, i_is_left, i_enable;
  logic [audio_width-1:0] i_audio;
  logic o_valid, o_ready, o_is_left;
  logic [audio_width-1:0] o_audio;
  logic mem_en, mem_we;
  logic [addr_width-1:0] mem_addr;
  logic [audio_width-1:0] mem_wdata, mem_rdata;
  logic o_sync_error;
  modport master (
    input i_valid, i_is_left, i_audio, i_enable, o_ready, mem_rdata,
    output i_ready, o_valid, o_is_left, o_audio, mem_en, mem_we, mem_addr, mem_wdata, o_sync_error
  );
  modport slave (
    output i_valid, i_is_left, i_audio, i_enable, o_ready, mem_rdata,
    input i_ready, o_valid, o_is_left, o_audio, mem_en, mem_we, mem_addr, mem_wdata, o_sync_error
  );
endinterface

// File: rtl/stereo_delay_line_controller.sv
// stereo_delay_line_controller: per-channel sample delay using read-before-write on an external single-port RAM
module stereo_delay_line_controller #(
  parameter int audio_width = 32,
  parameter int addr_width = 10,
  parameter int delay_samples = 512
) (
  input logic clk,
  input logic reset_n,
  stereo_delay_line_controller_if.master bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, OUT} state_t;
  localparam logic [addr_width-2:0] ptr_last = (addr_width-1)'(delay_samples - 1);
  state_t state;
  logic [addr_width-2:0] ptr;
  logic filled, expect_left, lat_left, lat_en;
  logic [audio_width-1:0] lat_audio;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      filled <= 1'b0;
      expect_left <= 1'b1;
      lat_left <= 1'b0;
      lat_en <= 1'b0;
      lat_audio <= '0;
      bus.i_ready <= 1'b1;
      bus.o_valid <= 1'b0;
      bus.o_is_left <= 1'b0;
      bus.o_audio <= '0;
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.o_sync_error <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.i_valid) begin
          state <= RD;
          bus.i_ready <= 1'b0;
          lat_audio <= bus.i_audio;
          lat_left <= bus.i_is_left;
          lat_en <= bus.i_enable;
          bus.o_sync_error <= bus.o_sync_error | (bus.i_is_left != expect_left);
          expect_left <= ~bus.i_is_left;
          bus.mem_en <= 1'b1;
          bus.mem_addr <= {ptr, ~bus.i_is_left};
        end
        RD: begin
          state <= WR;
          bus.mem_we <= 1'b1;
          bus.mem_wdata <= lat_audio;
        end
        WR: begin
          state <= OUT;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.o_valid <= 1'b1;
          bus.o_is_left <= lat_left;
          // until the line has wrapped once the RAM holds no real history
          bus.o_audio <= !lat_en ? lat_audio : filled ? bus.mem_rdata : '0;
        end
        OUT: if (bus.o_ready) begin
          state <= IDLE;
          bus.o_valid <= 1'b0;
          bus.i_ready <= 1'b1;
          if (!lat_left) begin
            ptr <= ptr == ptr_last ? '0 : ptr + 1'b1;
            filled <= filled | (ptr == ptr_last);
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_stereo_delay_line_controller.sv
// tb_stereo_delay_line_controller: directed checks of timing, delay, bypass, backpressure, sync error and reset abort
module tb_stereo_delay_line_controller;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ram [0:1023] = '{default: 32'hDEAD_BEEF};
  stereo_delay_line_controller_if #(.audio_width(32), .addr_width(10)) bus ();
  stereo_delay_line_controller #(.audio_width(32), .addr_width(10), .delay_samples(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr];
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic left, input logic [31:0] d, input logic en, input logic [9:0] addr, input logic [31:0] exp);
    int k;
    k = 0;
    while (bus.i_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("i_ready", 32'(bus.i_ready), 1);
    bus.i_valid = 1'b1;
    bus.i_is_left = left;
    bus.i_audio = d;
    bus.i_enable = en;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_enable = ~en;
    bus.i_audio = ~d;
    check("rd_ctl", 32'({bus.i_ready, bus.mem_en, bus.mem_we}), 32'b010);
    check("rd_addr", 32'(bus.mem_addr), 32'(addr));
    @(negedge clk);
    check("wr_ctl", 32'({bus.i_ready, bus.mem_en, bus.mem_we}), 32'b011);
    check("wr_addr", 32'(bus.mem_addr), 32'(addr));
    check("wr_data", bus.mem_wdata, d);
    @(negedge clk);
    check("out_ctl", 32'({bus.i_ready, bus.mem_en, bus.o_valid, bus.o_is_left}), 32'({3'b001, left}));
    check("out_audio", bus.o_audio, exp);
    if (bus.o_ready) begin
      @(negedge clk);
      check("done", 32'({bus.i_ready, bus.o_valid}), 32'b10);
    end
  endtask
  initial begin
    bus.i_valid = 1'b0;
    bus.i_is_left = 1'b0;
    bus.i_audio = '0;
    bus.i_enable = 1'b1;
    bus.o_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ctl", 32'({bus.o_valid, bus.o_is_left, bus.mem_en, bus.mem_we, bus.o_sync_error}), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_audio", bus.o_audio, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.i_ready), 1);
    for (int n = 1; n <= 8; n++) begin
      send(1'b1, 32'(n), 1'b1, 10'(2 * ((n - 1) % 4)), n > 4 ? 32'(n - 4) : 32'h0);
      send(1'b0, 32'(32'h100 + n), 1'b1, 10'(2 * ((n - 1) % 4) + 1), n > 4 ? 32'(32'h100 + n - 4) : 32'h0);
    end
    send(1'b1, 32'hABCD, 1'b0, 10'd0, 32'hABCD);
    send(1'b0, 32'h0123, 1'b0, 10'd1, 32'h0123);
    bus.o_ready = 1'b0;
    send(1'b1, 32'h77, 1'b1, 10'd2, 32'h6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_ctl", 32'({bus.i_ready, bus.mem_en, bus.o_valid}), 32'b001);
      check("bp_audio", bus.o_audio, 32'h6);
    end
    bus.o_ready = 1'b1;
    @(negedge clk);
    check("bp_done", 32'({bus.i_ready, bus.o_valid}), 32'b10);
    send(1'b0, 32'h177, 1'b1, 10'd3, 32'h106);
    check("sync0", 32'(bus.o_sync_error), 0);
    send(1'b1, 32'h21, 1'b1, 10'd4, 32'h7);
    check("sync1", 32'(bus.o_sync_error), 0);
    send(1'b1, 32'h22, 1'b1, 10'd4, 32'h21);
    check("sync2", 32'(bus.o_sync_error), 1);
    send(1'b0, 32'h23, 1'b1, 10'd5, 32'h107);
    check("sync3", 32'(bus.o_sync_error), 1);
    bus.i_valid = 1'b1;
    bus.i_is_left = 1'b1;
    bus.i_audio = 32'h99;
    bus.i_enable = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_ctl", 32'({bus.mem_en, bus.mem_we}), 32'b11);
    check("pre_rst_addr", 32'(bus.mem_addr), 6);
    reset_n = 1'b0;
    #1;
    check("rst_abort", 32'({bus.mem_en, bus.mem_we, bus.o_valid}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_write", ram[6], 32'h8);
    check("rst_sync", 32'(bus.o_sync_error), 0);
    for (int n = 1; n <= 5; n++) begin
      send(1'b1, 32'(32'h300 + n), 1'b1, 10'(2 * ((n - 1) % 4)), n > 4 ? 32'h301 : 32'h0);
      send(1'b0, 32'(32'h400 + n), 1'b1, 10'(2 * ((n - 1) % 4) + 1), n > 4 ? 32'h401 : 32'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
